pipelined_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 34 +++
 rtl/shift_stage.sv | 83 ++++++++
 rtl/pipelined_shifter.sv | 87 ++++++++
 tb/tb_pipelined_shifter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

    // Widest operand bit_rev can handle; N must not exceed this.
    localparam int unsigned REV_MAX_W = 256;
    localparam int unsigned REV_IDX_W = $clog2(REV_MAX_W);

    // Register stages needed to cover 'levels' shift levels, 'per_stage' at a time.
    function automatic int unsigned num_stages(input int unsigned levels,
                                               input int unsigned per_stage);
        return (levels + per_stage - 1) / per_stage;
    endfunction

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] x,
                                                     input int unsigned w);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REV_MAX_W; i++) begin
            if (i < w) begin
                r[REV_IDX_W'(i)] = x[REV_IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: shift levels [LO, HI), stage
// register and advance logic. Left shifts travel bit-reversed through the
// pipe: the first stage reverses on entry, the last stage reverses on exit.
// SHIFTER_ROTATE_EN builds the rotate path; otherwise SHIFT_ROR acts as SRL.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 2,
    parameter bit          FIRST = 1'b1,
    parameter bit          LAST  = 1'b0,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prev_valid,
    input  logic [N-1:0]      prev_data,
    input  logic [SW-1:0]     prev_shamt,
    input  shift_mode_t       prev_mode,
    input  logic [TAG_W-1:0]  prev_tag,
    input  logic              down_advance,
    output logic              advance_c,
    output logic              valid,
    output logic [N-1:0]      data,
    output logic [SW-1:0]     shamt,
    output shift_mode_t       mode,
    output logic [TAG_W-1:0]  tag
);

    logic [N-1:0] shifted;
    logic         fill;

    // Stage accepts new content when empty or when its content moves on.
    assign advance_c = !valid || down_advance;

    // Fixed shift levels of this stage, with entry/exit reversal for SLL.
    always_comb begin
        shifted = prev_data;
        if (FIRST && prev_mode == SHIFT_SLL) begin
            shifted = N'(bit_rev(REV_MAX_W'(shifted), N));
        end
        // Arithmetic right shifts keep the MSB, so it still holds the input sign.
        fill = (prev_mode == SHIFT_SRA) && shifted[N-1];
        for (int unsigned k = LO; k < HI; k++) begin
            if (|(prev_shamt & (SW'(1) << k))) begin
`ifdef SHIFTER_ROTATE_EN
                if (prev_mode == SHIFT_ROR) begin
                    shifted = (shifted >> (1 << k)) | (shifted << (N - (1 << k)));
                end else begin
                    shifted = (shifted >> (1 << k)) | (fill ? ~({N{1'b1}} >> (1 << k)) : '0);
                end
`else
                shifted = (shifted >> (1 << k)) | (fill ? ~({N{1'b1}} >> (1 << k)) : '0);
`endif
            end
        end
        if (LAST && prev_mode == SHIFT_SLL) begin
            shifted = N'(bit_rev(REV_MAX_W'(shifted), N));
        end
    end

    // Stage register; payload only loads with a valid operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            mode  <= SHIFT_SLL;
            tag   <= '0;
        end else if (advance_c) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data  <= shifted;
                shamt <= prev_shamt;
                mode  <= prev_mode;
                tag   <= prev_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined multi-mode barrel shifter with valid/ready stages that collapse
// bubbles. Optional macro SHIFTER_ROTATE_EN enables the SHIFT_ROR rotate.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned N                = 32,
    parameter int unsigned LEVELS_PER_STAGE = 2,
    parameter int unsigned TAG_W            = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         i_data,
    input  logic [$clog2(N)-1:0] i_shamt,
    input  shift_mode_t          i_mode,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [N-1:0]         o_data,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned L  = num_stages(SW, LEVELS_PER_STAGE);

    // Index 0 is the input port; index s+1 is the register of stage s.
    logic [L:0]       vld;
    logic [N-1:0]     dat [L+1];
    logic [SW-1:0]    sam [L+1];
    shift_mode_t      mod [L+1];
    logic [TAG_W-1:0] tg  [L+1];
    logic             adv [L];
    logic [L-1:0]     down_adv;
    logic             full_below;

    assign vld[0] = i_valid;
    assign dat[0] = i_data;
    assign sam[0] = i_shamt;
    assign mod[0] = i_mode;
    assign tg[0]  = i_tag;

    // Downstream of stage s moves when the output drains or any later stage is empty.
    always_comb begin
        full_below = 1'b1;
        down_adv   = '0;
        for (int s = L - 1; s >= 0; s--) begin
            down_adv[s] = o_ready || !full_below;
            full_below  = full_below && vld[s+1];
        end
    end

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int unsigned LO = s * LEVELS_PER_STAGE;
        localparam int unsigned HI = ((s + 1) * LEVELS_PER_STAGE < SW) ?
                                     (s + 1) * LEVELS_PER_STAGE : SW;
        shift_stage #(
            .N     (N),
            .TAG_W (TAG_W),
            .LO    (LO),
            .HI    (HI),
            .FIRST (s == 0),
            .LAST  (s == L - 1)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .prev_valid   (vld[s]),
            .prev_data    (dat[s]),
            .prev_shamt   (sam[s]),
            .prev_mode    (mod[s]),
            .prev_tag     (tg[s]),
            .down_advance (down_adv[s]),
            .advance_c    (adv[s]),
            .valid        (vld[s+1]),
            .data         (dat[s+1]),
            .shamt        (sam[s+1]),
            .mode         (mod[s+1]),
            .tag          (tg[s+1])
        );
    end

    assign i_ready = adv[0];
    assign o_valid = vld[L];
    assign o_data  = dat[L];
    assign o_tag   = tg[L];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed N=32 checks plus a
// randomized N=8, one-level-per-stage instance.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=32, two levels per stage
    logic        i_valid, i_ready, o_valid, o_ready;
    logic [31:0] i_data, o_data;
    logic [4:0]  i_shamt;
    shift_mode_t i_mode;
    logic [3:0]  i_tag, o_tag;

    // DUT B: N=8, one level per stage
    logic        b_i_valid, b_i_ready, b_o_valid, b_o_ready;
    logic [7:0]  b_i_data, b_o_data;
    logic [2:0]  b_i_shamt;
    shift_mode_t b_i_mode;
    logic [3:0]  b_i_tag, b_o_tag;

    pipelined_shifter #(.N(32), .LEVELS_PER_STAGE(2), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .i_shamt(i_shamt), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_tag(o_tag));

    pipelined_shifter #(.N(8), .LEVELS_PER_STAGE(1), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_i_valid), .i_ready(b_i_ready),
        .i_data(b_i_data), .i_shamt(b_i_shamt), .i_mode(b_i_mode), .i_tag(b_i_tag),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_tag(b_o_tag));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   out_cyc_a[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   outs_a = 0, accepted_a = 0;
    int   outs_b = 0, accepted_b = 0;
    logic [31:0] a_want;
    bit          a_lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference on the low w bits of d.
    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input shift_mode_t m, input int w);
        logic [63:0] mask, x, r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (m)
            SHIFT_SLL: r = x << s;
            SHIFT_SRL: r = x >> s;
            SHIFT_SRA: r = (x >> s) | (x[w-1] ? (mask & ~(mask >> s)) : 64'd0);
`ifdef SHIFTER_ROTATE_EN
            default:   r = (x >> s) | (x << (w - s));
`else
            default:   r = x >> s;
`endif
        endcase
        return 32'(r & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Scoreboard push at every input handshake of DUT A
    always @(negedge clk) begin
        if (rst_n && i_valid && i_ready) begin
            q_a.push_back('{data: a_want, tag: i_tag, cyc: cyc, chk_lat: a_lat});
            accepted_a++;
        end
    end

    // Output monitor for DUT A
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && o_valid && o_ready) begin
            if (q_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL a_unexpected: got data %h tag %h, expected no result", o_data, o_tag);
            end else begin
                e = q_a.pop_front();
                check("a_data", o_data, e.data);
                check("a_tag", 32'(o_tag), 32'(e.tag));
                if (e.chk_lat) check("a_latency", 32'(cyc - e.cyc), 32'(LAT));
                out_cyc_a.push_back(cyc);
                outs_a++;
            end
        end
    end

    // Scoreboard push at every input handshake of DUT B
    always @(negedge clk) begin
        if (rst_n && b_i_valid && b_i_ready) begin
            q_b.push_back('{data: model(32'(b_i_data), int'(b_i_shamt), b_i_mode, 8),
                            tag: b_i_tag, cyc: cyc, chk_lat: 1'b0});
            accepted_b++;
        end
    end

    // Output monitor for DUT B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_o_valid && b_o_ready) begin
            if (q_b.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL b_unexpected: got data %h, expected no result", b_o_data);
            end else begin
                e = q_b.pop_front();
                check("b_data", 32'(b_o_data), e.data);
                check("b_tag", 32'(b_o_tag), 32'(e.tag));
                outs_b++;
            end
        end
    end

    // Present one operation on DUT A and hold it until accepted; call at posedge+1.
    task automatic send_a(input logic [31:0] d, input logic [4:0] s, input shift_mode_t m,
                          input logic [3:0] t, input logic [31:0] want, input bit lat);
        bit done;
        i_valid = 1'b1; i_data = d; i_shamt = s; i_mode = m; i_tag = t;
        a_want = want; a_lat = lat;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (i_ready) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL a_accept_timeout: tag %h not accepted within 50 cycles", t);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    // Wait until DUT A's scoreboard is empty; returns at a negedge.
    task automatic drain_a();
        int n;
        n = 0;
        while (q_a.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL a_drain_timeout: %0d results outstanding, expected 0", q_a.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] bp_d [3];
    logic [31:0] bp_w [3];
    int base_acc, base_outs, idx, span;
    logic [31:0] sd;
    shift_mode_t sm;
    logic [4:0] ss;

    initial begin
        i_valid = 1'b0; i_data = '0; i_shamt = '0; i_mode = SHIFT_SLL; i_tag = '0; o_ready = 1'b1;
        a_want = '0; a_lat = 1'b0;
        b_i_valid = 1'b0; b_i_data = '0; b_i_shamt = '0; b_i_mode = SHIFT_SLL; b_i_tag = '0;
        b_o_ready = 1'b1;
        bp_d[0] = 32'hF000_0000; bp_w[0] = 32'hFFF0_0000;
        bp_d[1] = 32'h0000_FF00; bp_w[1] = 32'h0000_00FF;
        bp_d[2] = 32'hA5A5_A5A5; bp_w[2] = 32'hFFA5_A5A5;

        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_o_tag", 32'(o_tag), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd1);
        @(posedge clk); #1;

        // Directed modes, back to back with exact latency
        send_a(32'h0000_0001, 5'd31, SHIFT_SLL, 4'd1, 32'h8000_0000, 1'b1);
        send_a(32'h8000_0000, 5'd4,  SHIFT_SRL, 4'd2, 32'h0800_0000, 1'b1);
        send_a(32'h8000_0000, 5'd4,  SHIFT_SRA, 4'd3, 32'hF800_0000, 1'b1);
        send_a(32'h8000_0000, 5'd0,  SHIFT_SLL, 4'd4, 32'h8000_0000, 1'b1);
        send_a(32'h8000_0000, 5'd0,  SHIFT_SRL, 4'd5, 32'h8000_0000, 1'b1);
        send_a(32'h8000_0000, 5'd0,  SHIFT_SRA, 4'd6, 32'h8000_0000, 1'b1);
        send_a(32'h8000_0000, 5'd0,  SHIFT_ROR, 4'd7, 32'h8000_0000, 1'b1);
`ifdef SHIFTER_ROTATE_EN
        send_a(32'h0000_0001, 5'd1,  SHIFT_ROR, 4'd8, 32'h8000_0000, 1'b1);
`else
        send_a(32'h0000_0001, 5'd1,  SHIFT_ROR, 4'd8, 32'h0000_0000, 1'b1);
`endif
        drain_a();
        @(posedge clk); #1;

        // Stream of 8, tags 0..7, one result per cycle
        out_cyc_a.delete();
        for (int t = 0; t < 8; t++) begin
            sd = 32'h9E37_79B9 ^ (32'(t) * 32'h0101_0101);
            sm = shift_mode_t'(2'(t % 4));
            ss = 5'(3 * t + 1);
            send_a(sd, ss, sm, 4'(t), model(sd, int'(ss), sm, 32), 1'b1);
        end
        drain_a();
        check("stream_count", 32'(out_cyc_a.size()), 32'd8);
        span = (out_cyc_a.size() == 8) ? out_cyc_a[7] - out_cyc_a[0] : -1;
        check("stream_span", 32'(span), 32'd7);
        @(posedge clk); #1;

        // Backpressure: six cycles of feeding with o_ready low
        o_ready = 1'b0;
        base_acc = accepted_a;
        base_outs = outs_a;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            i_valid = 1'b1;
            i_data  = (idx < 3) ? bp_d[idx] : 32'h0000_0003;
            i_shamt = 5'd8; i_mode = SHIFT_SRA; i_tag = 4'(8 + idx);
            a_want  = (idx < 3) ? bp_w[idx] : 32'h0;
            a_lat   = 1'b0;
            @(negedge clk);
            if (i_ready) idx++;
            if (c >= 3) begin
                check("bp_o_valid", 32'(o_valid), 32'd1);
                check("bp_hold_data", o_data, 32'hFFF0_0000);
                check("bp_hold_tag", 32'(o_tag), 32'd8);
            end
            if (c == 5) check("bp_i_ready_full", 32'(i_ready), 32'd0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        check("bp_accepted", 32'(accepted_a - base_acc), 32'd3);
        o_ready = 1'b1;
        @(negedge clk);
        check("bp_i_ready_pop", 32'(i_ready), 32'd1);
        drain_a();
        check("bp_drained", 32'(outs_a - base_outs), 32'd3);
        @(posedge clk); #1;

        // Reset with two operations in flight
        send_a(32'h0000_0F00, 5'd8, SHIFT_SRL, 4'd14, 32'h0000_000F, 1'b0);
        send_a(32'h0000_00F0, 5'd4, SHIFT_SRL, 4'd15, 32'h0000_000F, 1'b0);
        rst_n = 1'b0;
        q_a.delete();
        base_outs = outs_a;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_o_valid", 32'(o_valid), 32'd0);
        check("rst_mid_i_ready", 32'(i_ready), 32'd1);
        repeat (6) @(negedge clk);
        check("rst_mid_no_stale", 32'(outs_a - base_outs), 32'd0);
        @(posedge clk); #1;

        // Randomized run on the N=8 instance
        for (int c = 0; c < 300; c++) begin
            b_i_valid = 1'($urandom_range(0, 1));
            b_i_data  = 8'($urandom);
            b_i_shamt = 3'($urandom_range(0, 7));
            b_i_mode  = shift_mode_t'(2'($urandom_range(0, 3)));
            b_i_tag   = 4'($urandom);
            b_o_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        b_i_valid = 1'b0;
        b_o_ready = 1'b1;
        for (int n = 0; n < 100 && q_b.size() != 0; n++) @(negedge clk);
        check("b_drain", 32'(q_b.size()), 32'd0);
        check("b_count", 32'(outs_b), 32'(accepted_b));
        check("a_final_empty", 32'(q_a.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
